// File: rtl/covered_gen.sv
// covered_gen: scans the grid row-major and emits a per-point {A,B,C}
// circle coverage vector through a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   en_i           start pulse, sampled only while idle
//   central_i      {xA,yA,xB,yB,xC,yC}, xA in the MSBs
//   radius_i       {rA,rB,rC}
//   mode_i         mode latched at start
//   ready_i        downstream accepts the current beat
//   covered_o      [2]=in A, [1]=in B, [0]=in C
//   mode_buf_o     mode held for the whole scan
//   valid_o        covered_o/last_o valid
//   last_o         beat for point (GRID_W,GRID_H)
//   busy_o         start accepted until last beat accepted

`ifndef MODE_SZ
`define MODE_SZ 2
`endif

`ifndef COVERED_SZ
`define COVERED_SZ 3
`endif

package covered_gen_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;
endpackage

module covered_gen
  import covered_gen_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int CW     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [6*CW-1:0]        central_i,
  input  logic [3*CW-1:0]        radius_i,
  input  logic [`MODE_SZ-1:0]    mode_i,
  input  logic                   ready_i,
  output logic [`COVERED_SZ-1:0] covered_o,
  output logic [`MODE_SZ-1:0]    mode_buf_o,
  output logic                   valid_o,
  output logic                   last_o,
  output logic                   busy_o
);

  localparam int DW = 2*CW+1;
  localparam int RW = 2*CW;

  localparam logic [CW-1:0] XMAX = CW'(GRID_W);
  localparam logic [CW-1:0] YMAX = CW'(GRID_H);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t state;

  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic [6*CW-1:0] cen;
  logic [3*CW-1:0] rad;

  logic s1_v;
  logic s1_last;

  logic s2_adv;
  logic s1_adv;
  logic issue;
  logic issue_last;
  logic done;

  logic [`COVERED_SZ-1:0] hit;

  // Each stage moves when the stage after it can take its data,
  // so empty stages keep filling while the output is held.
  assign s2_adv     = !valid_o || ready_i;
  assign s1_adv     = !s1_v || s2_adv;
  assign issue      = (state == SCAN) && s1_adv;
  assign issue_last = (x == XMAX) && (y == YMAX);
  assign done       = valid_o && ready_i && last_o;

  // Squared distance with exact signed deltas; CW+1 bits holds any
  // difference of two CW-bit unsigned values, so off-grid centres
  // never wrap.
  function automatic logic [DW-1:0] dist2(
    input logic [CW-1:0] px,
    input logic [CW-1:0] py,
    input logic [CW-1:0] qx,
    input logic [CW-1:0] qy
  );
    logic [CW:0]   dx;
    logic [CW:0]   dy;
    logic [2*CW+1:0] ex;
    logic [2*CW+1:0] ey;
    logic [2*CW+1:0] sx;
    logic [2*CW+1:0] sy;
    dx = {1'b0, px} - {1'b0, qx};
    dy = {1'b0, py} - {1'b0, qy};
    ex = {{(CW+1){dx[CW]}}, dx};
    ey = {{(CW+1){dy[CW]}}, dy};
    sx = ex * ex;
    sy = ey * ey;
    return sx[DW-1:0] + sy[DW-1:0];
  endfunction

  // Control: start, point counters, drain, busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      x          <= '0;
      y          <= '0;
      cen        <= '0;
      rad        <= '0;
      mode_buf_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en_i) begin
            cen        <= central_i;
            rad        <= radius_i;
            mode_buf_o <= mode_i;
            x          <= ONE;
            y          <= ONE;
            busy_o     <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (issue) begin
            if (issue_last) begin
              state <= DRAIN;
            end else if (x == XMAX) begin
              x <= ONE;
              y <= y + ONE;
            end else begin
              x <= x + ONE;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 valid/last tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
    end else if (s1_adv) begin
      s1_v    <= issue;
      s1_last <= issue && issue_last;
    end
  end

  // Per-circle datapath. Circle 0 is A and lands on covered_o[2].
  for (genvar g = 0; g < 3; g++) begin : g_circ
    logic [CW-1:0] xc;
    logic [CW-1:0] yc;
    logic [CW-1:0] rc;
    logic [DW-1:0] d2_q;
    logic [RW-1:0] r2_q;

    assign xc = cen[(5-2*g)*CW +: CW];
    assign yc = cen[(4-2*g)*CW +: CW];
    assign rc = rad[(2-g)*CW +: CW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_q <= '0;
        r2_q <= '0;
      end else if (issue) begin
        d2_q <= dist2(x, y, xc, yc);
        r2_q <= RW'(rc) * RW'(rc);
      end
    end

    // Inclusive: points on the circle count as covered.
    assign hit[2-g] = (d2_q <= DW'(r2_q));
  end

  // Stage 2: registered outputs, frozen while a beat is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      covered_o <= '0;
      last_o    <= 1'b0;
    end else if (s2_adv) begin
      valid_o   <= s1_v;
      covered_o <= s1_v ? hit : '0;
      last_o    <= s1_v && s1_last;
    end
  end

endmodule
